// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter in front of the single-port SRAM controller
// Optional build macro: SRAM_ARB_FIXED_PRIO_EN (port 0 always wins contention; port 1 can starve).
module sram_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              rw0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              mem,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic              grant;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              take;
  logic              pick;
  logic              capture;
`ifndef SRAM_ARB_FIXED_PRIO_EN
  logic              last_grant;
`endif

  // Port selection for the arbitration cycle; only consulted when take is high.
  always_comb begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
    pick = !req0;
`else
    if (req0 && req1) pick = !last_grant;
    else              pick = req1;
`endif
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          take      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: if (mem_ready) state_nxt = BUSY;
      BUSY: begin
        // ready returning high marks the controller back in idle with read data registered
        if (mem_ready) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem  = 1'b0;
    busy = 1'b0;
    ack0 = 1'b0;
    ack1 = 1'b0;
    if (state != IDLE) busy = 1'b1;
    if (state == ISSUE) mem = 1'b1;
    if (state == DONE) begin
      ack0 = !grant;
      ack1 = grant;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 1'b0;
      cmd_rw    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      if (take) begin
        grant     <= pick;
        cmd_rw    <= pick ? rw1    : rw0;
        cmd_addr  <= pick ? addr1  : addr0;
        cmd_wdata <= pick ? wdata1 : wdata0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        last_grant <= pick;
`endif
      end
      if (capture && cmd_rw) begin
        if (grant) rdata1 <= mem_rdata;
        else       rdata0 <= mem_rdata;
      end
    end
  end

  assign mem_rw    = cmd_rw;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with a behavioural SRAM controller model
module tb_sram_arbiter;

  typedef struct {
    logic        rw;
    logic [18:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  typedef struct {
    int         port;
    int         cyc;
    logic [7:0] r0;
    logic [7:0] r1;
  } exp_t;

  logic        clk, reset;
  logic        req0, rw0, req1, rw1;
  logic [18:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1, busy, mem, mem_rw, mem_ready;
  logic [7:0]  rdata0, rdata1, mem_wdata, mem_rdata;
  logic [18:0] mem_addr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  exp_t sb[$];
  cmd_t cq0[$];
  cmd_t cq1[$];

  // controller model: idle -> op1 -> op2 -> idle, ready only in idle
  bit [7:0]    sram [int];
  logic [1:0]  ctl_st;
  logic        ctl_rw;
  logic [18:0] ctl_addr;
  logic [7:0]  ctl_rdata;
  int          stall_req = 0;
  int          stall_used = 0;

  // monitor bookkeeping
  int          mem_total = 0;
  int          mem_rise = -1;
  int          stable_err = 0;
  logic        mem_prev = 1'b0;
  logic        exp_rw = 1'b0;
  logic [18:0] exp_addr = '0;
  logic [7:0]  exp_wdata = '0;

  sram_arbiter #(.ADDR_W(19), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .mem(mem), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_ready = (ctl_st == 2'd0) && (stall_used == stall_req);
  assign mem_rdata = ctl_rdata;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_st    <= 2'd0;
      ctl_rw    <= 1'b0;
      ctl_addr  <= '0;
      ctl_rdata <= '0;
    end else begin
      case (ctl_st)
        2'd0: begin
          if (mem) begin
            if (stall_used != stall_req) stall_used <= stall_used + 1;
            else begin
              ctl_st   <= 2'd1;
              ctl_rw   <= mem_rw;
              ctl_addr <= mem_addr;
              if (!mem_rw) sram[int'(mem_addr)] = mem_wdata;
            end
          end
        end
        2'd1: ctl_st <= 2'd2;
        default: begin
          ctl_st <= 2'd0;
          if (ctl_rw) ctl_rdata <= sram[int'(ctl_addr)];
        end
      endcase
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   gp;
    if (mem) begin
      mem_total++;
      if (!mem_prev) mem_rise = cyc;
      if (mem_rw !== exp_rw || mem_addr !== exp_addr || mem_wdata !== exp_wdata) stable_err++;
    end
    mem_prev = mem;
    if (ack0 || ack1) begin
      checks++;
      gp = ack1 ? 1 : 0;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack actual port=%0d cyc=%0d required=no ack", gp, cyc);
      end else begin
        e = sb.pop_front();
        if ((ack0 && ack1) || gp != e.port || cyc != e.cyc || rdata0 !== e.r0 || rdata1 !== e.r1) begin
          failures++;
          $display("FAIL ack actual port=%0d cyc=%0d r0=%h r1=%h both=%0b required port=%0d cyc=%0d r0=%h r1=%h",
                   gp, cyc, rdata0, rdata1, ack0 && ack1, e.port, e.cyc, e.r0, e.r1);
        end
      end
    end
  end

  function automatic cmd_t mk_cmd(input logic rw, input logic [18:0] a, input logic [7:0] d);
    cmd_t c;
    c.rw = rw; c.addr = a; c.wdata = d;
    return c;
  endfunction

  function automatic exp_t mk_exp(input int p, input int cy, input logic [7:0] r0, input logic [7:0] r1);
    exp_t e;
    e.port = p; e.cyc = cy; e.r0 = r0; e.r1 = r1;
    return e;
  endfunction

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic drive(input int p, input logic r, input cmd_t c);
    if (p == 0) begin req0 = r; rw0 = c.rw; addr0 = c.addr; wdata0 = c.wdata; end
    else        begin req1 = r; rw1 = c.rw; addr1 = c.addr; wdata1 = c.wdata; end
  endtask

  task automatic run_port(input int p);
    cmd_t c;
    int   n;
    bit   got;
    int   k;
    n = (p == 0) ? cq0.size() : cq1.size();
    for (int i = 0; i < n; i++) begin
      c = (p == 0) ? cq0[i] : cq1[i];
      drive(p, 1'b1, c);
      got = 1'b0;
      k = 0;
      while (!got && k < 200) begin
        @(negedge clk);
        got = (p == 0) ? ack0 : ack1;
        k++;
      end
      check($sformatf("ack_seen_port%0d", p), int'(got), 1);
      @(posedge clk); #1;
      if (i == n - 1) drive(p, 1'b0, c);
    end
  endtask

  task automatic run_both();
    fork
      run_port(0);
      run_port(1);
    join
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    cq0.delete();
    cq1.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req0 = 1'b0; rw0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; rw1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_outputs", {ack0, ack1, busy, mem, rdata0, rdata1}, 0);
  endtask

  initial begin
    int c;
    int snap_mem;
    int snap_err;
    logic [7:0] r0;
    logic [7:0] r1;
    reset = 1'b1;
    sram[32'h12] = 8'hA5;
    sram[32'h1]  = 8'h11;
    sram[32'h2]  = 8'h22;
    for (int i = 0; i < 4; i++) begin
      sram[32'h20 + i] = 8'h40 + 8'(i);
      sram[32'h30 + i] = 8'h80 + 8'(i);
    end

    // single read on port 0
    apply_reset();
    snap_mem = mem_total;
    c = cyc;
    sb.push_back(mk_exp(0, c + 5, 8'hA5, 8'h00));
    cq0.push_back(mk_cmd(1'b1, 19'h00012, 8'h00));
    run_both();
    check("t1_mem_cycles", mem_total - snap_mem, 1);
    check("t1_mem_rise", mem_rise, c + 1);

    // write then read back on port 1
    apply_reset();
    c = cyc;
    sb.push_back(mk_exp(1, c + 5, 8'h00, 8'h00));
    sb.push_back(mk_exp(1, c + 11, 8'h00, 8'h3C));
    cq1.push_back(mk_cmd(1'b0, 19'h7FFFF, 8'h3C));
    cq1.push_back(mk_cmd(1'b1, 19'h7FFFF, 8'h00));
    run_both();

    // simultaneous requests from reset
    apply_reset();
    c = cyc;
    sb.push_back(mk_exp(0, c + 5, 8'h11, 8'h00));
    sb.push_back(mk_exp(1, c + 11, 8'h11, 8'h22));
    cq0.push_back(mk_cmd(1'b1, 19'h00001, 8'h00));
    cq1.push_back(mk_cmd(1'b1, 19'h00002, 8'h00));
    run_both();

    // continuous contention, 4 reads per port
    apply_reset();
    c = cyc;
    r0 = 8'h00;
    r1 = 8'h00;
    for (int k = 0; k < 8; k++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      if (k < 4) begin r0 = 8'h40 + 8'(k);     sb.push_back(mk_exp(0, c + 5 + 6 * k, r0, r1)); end
      else       begin r1 = 8'h80 + 8'(k - 4); sb.push_back(mk_exp(1, c + 5 + 6 * k, r0, r1)); end
`else
      if (k % 2 == 0) begin r0 = 8'h40 + 8'(k / 2); sb.push_back(mk_exp(0, c + 5 + 6 * k, r0, r1)); end
      else            begin r1 = 8'h80 + 8'(k / 2); sb.push_back(mk_exp(1, c + 5 + 6 * k, r0, r1)); end
`endif
    end
    for (int i = 0; i < 4; i++) begin
      cq0.push_back(mk_cmd(1'b1, 19'h20 + 19'(i), 8'h00));
      cq1.push_back(mk_cmd(1'b1, 19'h30 + 19'(i), 8'h00));
    end
    run_both();

    // reset in the middle of a port-0 read
    apply_reset();
    drive(0, 1'b1, mk_cmd(1'b1, 19'h00012, 8'h00));
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("t5_abort_state", {busy, mem, ack0, rdata0}, 0);
    drive(0, 1'b0, mk_cmd(1'b1, 19'h00012, 8'h00));
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_pending", {busy, rdata0}, 0);
    c = cyc;
    sb.push_back(mk_exp(0, c + 5, 8'hA5, 8'h00));
    cq0.push_back(mk_cmd(1'b1, 19'h00012, 8'h00));
    run_both();

    // controller stalls ISSUE for 3 cycles
    apply_reset();
    exp_rw = 1'b0;
    exp_addr = 19'h0ABCD;
    exp_wdata = 8'h5A;
    snap_mem = mem_total;
    snap_err = stable_err;
    stall_req = stall_used + 3;
    c = cyc;
    sb.push_back(mk_exp(0, c + 8, 8'h00, 8'h00));
    cq0.push_back(mk_cmd(1'b0, 19'h0ABCD, 8'h5A));
    run_both();
    check("t6_mem_cycles", mem_total - snap_mem, 4);
    check("t6_cmd_stable_errs", stable_err - snap_err, 0);
    check("t6_mem_rise", mem_rise, c + 1);
    check("t6_written", int'(sram[32'h0ABCD]), 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
